mul_acc_4bit: RTL and testbench

MUL_ACC_4BIT -- requirements
Module: mul_acc_4bit

---
 rtl/mul_pkg.sv | 31 +++
 rtl/mul_acc_fifo.sv | 68 ++++++
 rtl/mul_acc_4bit.sv | 106 ++++++++++
 tb/tb_mul_acc_4bit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared sizing, result record and pointer helper for the grouped
// multiply-accumulate block and its result buffer.
package mul_pkg;

  localparam int SIZE    = 4;
  localparam int LAT     = 2;
  localparam int ACC_W   = 12;
  localparam int MAX_GRP = 16;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 5;
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CR_W    = $clog2(DEPTH + LAT + 1);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             forced;
  } res_entry_t;

  typedef struct packed {
    logic valid;
    logic last;
    logic forced;
  } trk_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/mul_acc_fifo.sv
// Result buffer: DEPTH-entry synchronous FIFO whose head is held in output
// registers, so valid/data never come from a combinational read path.
module mul_acc_fifo
  import mul_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  res_entry_t       push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output res_entry_t       data_o,
  output logic [OCC_W-1:0] occ_o
);

  res_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  res_entry_t       data_q, data_d, head_s;
  logic             pop_s, push_s;

  // Pointer/occupancy update and look-ahead of the next head entry.
  always_comb begin
    pop_s    = pop_i & valid_q;
    push_s   = push_i & ((occ_q != OCC_W'(DEPTH)) | pop_s);
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // A push landing on the slot that becomes head must bypass the array.
    if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_s = push_data_i;
    end else begin
      head_s = mem_q[rd_ptr_d];
    end
    valid_d = (occ_d != {OCC_W{1'b0}});
    data_d  = valid_d ? head_s : '0;
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      if (push_s) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/mul_acc_4bit.sv
// Grouped accumulator behind an external LAT-deep multiplier: tracks accepted
// pairs to their products, sums each group and queues results under credit.
module mul_acc_4bit
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              op_last,
  output logic              op_ready,
  input  logic [2*SIZE-1:0] mul_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_forced
);

  trk_t             trk_q [LAT];
  trk_t             trk_in_s, trk_out_s;
  logic [CNT_W-1:0] grp_cnt_q, grp_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_s;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_s;
  logic             start_q, start_d;
  logic             accept_s, grp_full_s, push_s;
  logic [OCC_W-1:0] occ_s;
  logic [CR_W-1:0]  credit_s;
  res_entry_t       push_entry_s, head_s;

  // Issue side: acceptance, effective-last and group counting.
  always_comb begin
    accept_s        = op_valid & op_ready;
    grp_full_s      = (grp_cnt_q == CNT_W'(MAX_GRP - 1));
    trk_in_s.valid  = accept_s;
    trk_in_s.last   = accept_s & (op_last | grp_full_s);
    trk_in_s.forced = accept_s & grp_full_s & ~op_last;
    if (!accept_s) begin
      grp_cnt_d = grp_cnt_q;
    end else if (trk_in_s.last) begin
      grp_cnt_d = {CNT_W{1'b0}};
    end else begin
      grp_cnt_d = grp_cnt_q + CNT_W'(1);
    end
  end

  // Credit: every result already buffered or still in the delay line holds a slot.
  always_comb begin
    credit_s = CR_W'(occ_s);
    for (int i = 0; i < LAT; i++) credit_s = credit_s + CR_W'(trk_q[i].last);
    op_ready = (credit_s < CR_W'(DEPTH));
  end

  // Accumulate side, aligned with the product of the tracked pair.
  always_comb begin
    trk_out_s           = trk_q[LAT-1];
    sum_s               = (start_q ? {ACC_W{1'b0}} : acc_q) + ACC_W'(mul_out);
    cnt_s               = (start_q ? {CNT_W{1'b0}} : acc_cnt_q) + CNT_W'(1);
    push_s              = trk_out_s.valid & trk_out_s.last;
    push_entry_s.sum    = sum_s;
    push_entry_s.cnt    = cnt_s;
    push_entry_s.forced = trk_out_s.forced;
    if (trk_out_s.valid) begin
      acc_d     = sum_s;
      acc_cnt_d = cnt_s;
      start_d   = trk_out_s.last;
    end else begin
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      start_d   = start_q;
    end
  end

  // Delay line, group counter and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) trk_q[i] <= '0;
      grp_cnt_q <= {CNT_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      acc_cnt_q <= {CNT_W{1'b0}};
      start_q   <= 1'b1;
    end else begin
      trk_q[0] <= trk_in_s;
      for (int i = 1; i < LAT; i++) trk_q[i] <= trk_q[i-1];
      grp_cnt_q <= grp_cnt_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      start_q   <= start_d;
    end
  end

  mul_acc_fifo u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (push_s),
    .push_data_i(push_entry_s),
    .pop_i      (res_ready),
    .valid_o    (res_valid),
    .data_o     (head_s),
    .occ_o      (occ_s)
  );

  assign res_data   = head_s.sum;
  assign res_cnt    = head_s.cnt;
  assign res_forced = head_s.forced;

endmodule

// File: tb/tb_mul_acc_4bit.sv
// Self-checking bench for mul_acc_4bit with a behavioural 2-stage multiplier
// and a group-level reference model.
module tb_mul_acc_4bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_last = 1'b0;
  logic        res_ready = 1'b0;
  logic [3:0]  op_a = 4'd0;
  logic [3:0]  op_b = 4'd0;
  logic [7:0]  mul_p1 = 8'd0;
  logic [7:0]  mul_out = 8'd0;
  logic        op_ready, res_valid, res_forced;
  logic [11:0] res_data;
  logic [4:0]  res_cnt;

  typedef struct packed {
    logic [15:0] sum;
    logic [4:0]  cnt;
    logic        forced;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   obs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_sum = 0;
  int   m_n = 0;

  mul_acc_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_last   (op_last),
    .op_ready  (op_ready),
    .mul_out   (mul_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cnt   (res_cnt),
    .res_forced(res_forced)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mul_p1  <= op_a * op_b;
    mul_out <= mul_p1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model at group level plus result collection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum = 0;
      m_n   = 0;
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        obs_q.push_back(rec_t'{sum: 16'(res_data), cnt: res_cnt, forced: res_forced});
        obs_cyc.push_back(cyc);
      end
      if (op_valid && op_ready) begin
        m_sum = m_sum + op_a * op_b;
        m_n   = m_n + 1;
        if (op_last || m_n == 16) begin
          exp_q.push_back(rec_t'{sum: 16'(m_sum), cnt: 5'(m_n), forced: !op_last});
          m_sum = 0;
          m_n   = 0;
        end
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int guard = 0;
    op_a = a; op_b = b; op_last = last; op_valid = 1'b1;
    while (!op_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout: op_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int guard = 0;
    while (obs_q.size() < n && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 12'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", res_data); end
    checks++; if (res_cnt !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", res_cnt); end
    checks++; if (res_forced !== 1'b0) begin errors++; $display("FAIL rst_forced: got %b want 0", res_forced); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", op_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_group_latency();
    int t0;
    bit ok;
    clear_queues();
    res_ready = 1'b1;
    t0 = cyc;
    send(4'd3, 4'd5, 1'b0);
    send(4'd15, 4'd15, 1'b0);
    send(4'd0, 4'd7, 1'b1);
    idle();
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL grp_timeout: got %0d results want 1", obs_q.size());
    end else begin
      checks++; if (obs_cyc[0] - t0 !== 5) begin errors++; $display("FAIL grp_latency: got %0d want 5", obs_cyc[0] - t0); end
      checks++; if (obs_q[0].sum !== 16'd240) begin errors++; $display("FAIL grp_sum: got %0d want 240", obs_q[0].sum); end
      checks++; if (obs_q[0].cnt !== 5'd3) begin errors++; $display("FAIL grp_cnt: got %0d want 3", obs_q[0].cnt); end
      checks++; if (obs_q[0].forced !== 1'b0) begin errors++; $display("FAIL grp_forced: got %b want 0", obs_q[0].forced); end
    end
  endtask

  task automatic test_forced_close();
    bit ok;
    clear_queues();
    res_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(4'd15, 4'd15, 1'b0);
    send(4'd2, 4'd3, 1'b1);
    idle();
    wait_obs(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL forced_timeout: got %0d results want 2", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== rec_t'{sum: 16'd3600, cnt: 5'd16, forced: 1'b1}) begin
        errors++; $display("FAIL forced_group: got sum=%0d cnt=%0d f=%b want 3600/16/1", obs_q[0].sum, obs_q[0].cnt, obs_q[0].forced);
      end
      checks++; if (obs_q[1] !== rec_t'{sum: 16'd6, cnt: 5'd1, forced: 1'b0}) begin
        errors++; $display("FAIL after_forced: got sum=%0d cnt=%0d f=%b want 6/1/0", obs_q[1].sum, obs_q[1].cnt, obs_q[1].forced);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rec_t head;
    clear_queues();
    res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(4'd1, 4'(k), 1'b1);
    op_a = 4'd9; op_b = 4'd9; op_last = 1'b1;
    checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b want 0", op_ready); end
    head = exp_q[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold: cycle %0d got %b want 0", i, op_ready); end
      checks++; if (res_valid !== 1'b1 || res_data !== head.sum[11:0] || res_cnt !== head.cnt) begin
        errors++; $display("FAIL bp_stable: cycle %0d got v=%b d=%0d c=%0d want 1/%0d/%0d", i, res_valid, res_data, res_cnt, head.sum, head.cnt);
      end
    end
    idle();
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", op_ready); end
    wait_obs(4, ok);
    repeat (10) @(negedge clk);
    checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d results want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i].sum !== 16'(i + 1) || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_order[%0d]: got sum=%0d want %0d", i, obs_q[i].sum, i + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t0;
    clear_queues();
    res_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    idle();
    wait_obs(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout: got %0d results want 8", obs_q.size());
    end else begin
      checks++; if (obs_cyc[0] - t0 !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", obs_cyc[0] - t0); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== obs_cyc[0] + i) begin
          errors++; $display("FAIL b2b[%0d]: got sum=%0d cyc+%0d want sum=%0d cyc+%0d", i, obs_q[i].sum, obs_cyc[i] - obs_cyc[0], exp_q[i].sum, i);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    bit ok;
    clear_queues();
    res_ready = 1'b1;
    send(4'd5, 4'd5, 1'b0);
    send(4'd6, 4'd6, 1'b1);
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_outputs: got v=%b rdy=%b want 0/1", res_valid, op_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL mid_rst_discard: got %0d results want 0", obs_q.size()); end
    send(4'd4, 4'd4, 1'b1);
    idle();
    wait_obs(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL post_rst_timeout: got %0d results want 1", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== rec_t'{sum: 16'd16, cnt: 5'd1, forced: 1'b0}) begin
        errors++; $display("FAIL post_rst_group: got sum=%0d cnt=%0d want 16/1", obs_q[0].sum, obs_q[0].cnt);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_queues();
    res_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
      res_ready = ($urandom_range(0, 2) != 0);
      if (!op_ready) res_ready = 1'b1;
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), (n == 149) || ($urandom_range(0, 5) == 0));
    end
    idle();
    res_ready = 1'b1;
    wait_obs(exp_q.size(), ok);
    repeat (8) @(negedge clk);
    checks++; if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i, obs_q[i].sum, obs_q[i].cnt, obs_q[i].forced, exp_q[i].sum, exp_q[i].cnt, exp_q[i].forced);
      end
    end
  endtask

  initial begin
    test_reset();
    test_group_latency();
    test_forced_close();
    test_backpressure();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
